two_power_inv_mod: RTL and testbench

//   Computes o_out = i_value * 2^(-i_power) mod i_modulus for odd modulus by

---
 rtl/two_power_inv_mod_if.sv | 24 ++
 rtl/two_power_inv_mod.sv | 90 +++++++++
 tb/tb_two_power_inv_mod.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/two_power_inv_mod_if.sv
// Request/response bundle for the modular halving unit: request side (i_*) and result side (o_*).
interface two_power_inv_mod_if #(
    parameter int unsigned MOD_WIDTH   = 256,
    parameter int unsigned POWER_WIDTH = 32
);
    logic                   i_valid;
    logic                   i_ready;
    logic [MOD_WIDTH-1:0]   i_modulus;
    logic [MOD_WIDTH-1:0]   i_value;
    logic [POWER_WIDTH-1:0] i_power;
    logic                   o_valid;
    logic                   o_ready;
    logic [MOD_WIDTH-1:0]   o_out;

    modport master (
        output i_valid, i_modulus, i_value, i_power, o_ready,
        input  i_ready, o_valid, o_out
    );

    modport slave (
        input  i_valid, i_modulus, i_value, i_power, o_ready,
        output i_ready, o_valid, o_out
    );
endinterface

// File: rtl/two_power_inv_mod.sv
// Computes x * 2^(-P) mod N (N odd) by iterated modular halving, one halving per clock.
// Used to leave the Montgomery domain and to build 2^(-k) mod N.
module two_power_inv_mod #(
    parameter int unsigned MOD_WIDTH   = 256,
    parameter int unsigned POWER_WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    two_power_inv_mod_if.slave bus
);

    localparam int unsigned SUM_WIDTH = MOD_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [MOD_WIDTH-1:0]   r_acc;
    logic [MOD_WIDTH-1:0]   w_acc_nxt;
    logic [MOD_WIDTH-1:0]   r_modulus;
    logic [MOD_WIDTH-1:0]   w_modulus_nxt;
    logic [POWER_WIDTH-1:0] r_count;
    logic [POWER_WIDTH-1:0] w_count_nxt;
    logic                   r_ready;
    logic                   r_valid;
    logic [SUM_WIDTH-1:0]   w_sum;

    // Odd acc: add N in one extra bit so the carry survives the shift.
    assign w_sum = {1'b0, r_acc} + {1'b0, r_modulus};

    always_comb begin
        w_next_state  = r_state;
        w_acc_nxt     = r_acc;
        w_modulus_nxt = r_modulus;
        w_count_nxt   = r_count;
        case (r_state)
            S_IDLE: begin
                if (bus.i_valid) begin
                    w_modulus_nxt = bus.i_modulus;
                    w_acc_nxt     = bus.i_value;
                    w_count_nxt   = bus.i_power;
                    w_next_state  = (bus.i_power == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                w_acc_nxt   = r_acc[0] ? w_sum[SUM_WIDTH-1:1] : {1'b0, r_acc[MOD_WIDTH-1:1]};
                w_count_nxt = r_count - POWER_WIDTH'(1);
                if (r_count == POWER_WIDTH'(1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.o_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_modulus <= '0;
            r_count   <= '0;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_acc     <= w_acc_nxt;
            r_modulus <= w_modulus_nxt;
            r_count   <= w_count_nxt;
            r_ready   <= (w_next_state == S_IDLE);
            r_valid   <= (w_next_state == S_DONE);
        end
    end

    // acc only moves in CALC or on acceptance, so o_out is stable while DONE waits.
    assign bus.i_ready = r_ready;
    assign bus.o_valid = r_valid;
    assign bus.o_out   = r_acc;

endmodule

// File: tb/tb_two_power_inv_mod.sv
// Directed plus randomized checks of two_power_inv_mod against a modular-inverse reference model.
module tb_two_power_inv_mod;

    localparam int unsigned MW = 256;
    localparam int unsigned PW = 32;
    localparam int unsigned DW = 2 * MW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    two_power_inv_mod_if #(.MOD_WIDTH(MW), .POWER_WIDTH(PW)) bus ();

    two_power_inv_mod #(.MOD_WIDTH(MW), .POWER_WIDTH(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MW-1:0] rand_word();
        logic [MW-1:0] r;
        for (int k = 0; k < MW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [MW-1:0] mulmod(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                             input logic [MW-1:0] n);
        logic [DW-1:0] pr;
        pr = DW'(a) * DW'(b);
        pr = pr % DW'(n);
        return pr[MW-1:0];
    endfunction

    function automatic logic [MW-1:0] powmod(input logic [MW-1:0] b, input logic [PW-1:0] e,
                                             input logic [MW-1:0] n);
        logic [MW-1:0] r;
        logic [MW-1:0] base;
        logic [PW-1:0] ee;
        r    = mulmod(MW'(1), MW'(1), n);
        base = mulmod(b, MW'(1), n);
        ee   = e;
        while (ee != '0) begin
            if (ee[0]) r = mulmod(r, base, n);
            base = mulmod(base, base, n);
            ee   = ee >> 1;
        end
        return r;
    endfunction

    // x * (2^-1)^P mod N, where 2^-1 = (N+1)/2 for odd N.
    function automatic logic [MW-1:0] model(input logic [MW-1:0] n, input logic [MW-1:0] x,
                                            input logic [PW-1:0] p);
        logic [MW:0] t;
        t = ({1'b0, n} + (MW+1)'(1)) >> 1;
        return mulmod(x, powmod(t[MW-1:0], p, n), n);
    endfunction

    task automatic start_req(input logic [MW-1:0] n, input logic [MW-1:0] x, input logic [PW-1:0] p);
        int guard = 0;
        while (!bus.i_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("req_ready", MW'(bus.i_ready), MW'(1));
        bus.i_valid   = 1'b1;
        bus.i_modulus = n;
        bus.i_value   = x;
        bus.i_power   = p;
        @(posedge clk); #1;
        bus.i_valid   = 1'b0;
        bus.i_modulus = rand_word();
        bus.i_value   = rand_word();
        bus.i_power   = PW'($urandom);
    endtask

    task automatic wait_result(input logic [PW-1:0] p, output logic [MW-1:0] out, output int lat);
        lat = 0;
        while (!bus.o_valid && lat < int'(p) + 10) begin
            @(posedge clk); #1;
            lat++;
        end
        out = bus.o_out;
    endtask

    task automatic finish_req();
        bus.o_ready = 1'b1;
        @(posedge clk); #1;
        bus.o_ready = 1'b0;
    endtask

    task automatic run_req(input string tag, input logic [MW-1:0] n, input logic [MW-1:0] x,
                           input logic [PW-1:0] p, input logic [MW-1:0] exp);
        logic [MW-1:0] out;
        int            lat;
        start_req(n, x, p);
        wait_result(p, out, lat);
        check({tag, "_out"}, out, exp);
        check({tag, "_lat"}, MW'(lat), MW'(p));
        finish_req();
    endtask

    initial begin
        logic [MW-1:0] n;
        logic [MW-1:0] x;
        logic [MW-1:0] out;
        logic [PW-1:0] p;
        int            lat;

        bus.i_valid   = 1'b0;
        bus.i_modulus = '0;
        bus.i_value   = '0;
        bus.i_power   = '0;
        bus.o_ready   = 1'b0;

        #12;
        check("rst_i_ready", MW'(bus.i_ready), MW'(1));
        check("rst_o_valid", MW'(bus.o_valid), MW'(0));
        check("rst_o_out",   bus.o_out, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_i_ready", MW'(bus.i_ready), MW'(1));
        check("post_rst_o_valid", MW'(bus.o_valid), MW'(0));
        check("post_rst_o_out",   bus.o_out, '0);

        run_req("n13_p4", MW'(13), MW'(1), PW'(4), MW'(9));
        run_req("n13_p0", MW'(13), MW'(5), PW'(0), MW'(5));
        n = '1;
        run_req("wide_carry", n, n - MW'(2), PW'(1), n - MW'(1));

        // Backpressure: result held, new requests ignored while DONE waits.
        start_req(MW'(13), MW'(1), PW'(4));
        wait_result(PW'(4), out, lat);
        check("stall_lat", MW'(lat), MW'(4));
        bus.i_valid   = 1'b1;
        bus.i_modulus = MW'(13);
        bus.i_value   = MW'(3);
        bus.i_power   = PW'(0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("stall_o_out",   bus.o_out, MW'(9));
            check("stall_o_valid", MW'(bus.o_valid), MW'(1));
            check("stall_i_ready", MW'(bus.i_ready), MW'(0));
        end
        bus.i_valid = 1'b0;
        finish_req();
        run_req("b2b_p1", MW'(13), MW'(1), PW'(1), MW'(7));

        // Reset in the middle of a long halving run.
        start_req(MW'(13), MW'(1), PW'(50));
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        check("abort_i_ready", MW'(bus.i_ready), MW'(1));
        check("abort_o_valid", MW'(bus.o_valid), MW'(0));
        check("abort_o_out",   bus.o_out, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("abort_after_o_valid", MW'(bus.o_valid), MW'(0));
            check("abort_after_o_out",   bus.o_out, '0);
        end
        run_req("after_abort", MW'(13), MW'(1), PW'(1), MW'(7));

        for (int i = 0; i < 500; i++) begin
            n    = rand_word() >> $urandom_range(0, 250);
            n[0] = 1'b1;
            x    = rand_word() % n;
            p    = (i % 5 == 0) ? PW'($urandom_range(0, 600)) : PW'($urandom_range(0, 120));
            start_req(n, x, p);
            wait_result(p, out, lat);
            check("rand_out", out, model(n, x, p));
            check("rand_lat", MW'(lat), MW'(p));
            check("rand_inverse", mulmod(out, powmod(MW'(2), p, n), n), x);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            check("rand_hold", bus.o_out, out);
            finish_req();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
